// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: sequences the boot of the RV32I core.
// It streams a data image and then a program image from a valid/ready
// source into the data and instruction BRAMs. While loading it owns the
// data BRAM write port. It releases the core once both images are written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; CPU stalled, CPU stores dropped
// LOAD_D  | accepting data-image words into the data BRAM
// LOAD_I  | accepting program-image words into the instruction BRAM
// RUN     | core released; CPU owns the data BRAM write port
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [ADDR_WIDTH-3:0] d_count,
  input  logic [ADDR_WIDTH-3:0] i_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] imem_w_addr,
  output logic [DATA_WIDTH-1:0] imem_w_dat,
  output logic                  imem_w_enb,
  input  logic [ADDR_WIDTH-1:0] cpu_d_w_addr,
  input  logic [DATA_WIDTH-1:0] cpu_d_w_dat,
  input  logic                  cpu_d_w_enb,
  output logic [ADDR_WIDTH-1:0] dmem_w_addr,
  output logic [DATA_WIDTH-1:0] dmem_w_dat,
  output logic                  dmem_w_enb,
  output logic                  cpu_run,
  output logic                  busy
);

  localparam int IW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_D = 2'd1,
    ST_LOAD_I = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_d_cnt;
  logic [IW-1:0]         r_i_cnt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [IW-1:0]         w_cnt_sel;
  logic                  w_loading;
  logic                  w_accept;
  logic                  w_last;
  logic                  r_cpu_run;
  logic                  r_wr_enb_d;
  logic                  r_wr_enb_i;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_dat;
  logic                  w_cpu_owns_dmem;

  // Handshake and last-word detection for the image currently being loaded.
  always_comb begin
    w_loading = (r_state == ST_LOAD_D) || (r_state == ST_LOAD_I);
    w_accept  = w_loading && s_valid;
    w_cnt_sel = (r_state == ST_LOAD_D) ? r_d_cnt : r_i_cnt;
    w_last    = w_accept && (r_idx == (w_cnt_sel - IW'(1)));
  end

  // Next-state and word-index logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_idx_nxt = '0;
          if (d_count != '0)      w_state_nxt = ST_LOAD_D;
          else if (i_count != '0) w_state_nxt = ST_LOAD_I;
          else                    w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD_D: begin
        if (w_accept) w_idx_nxt = r_idx + IW'(1);
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = (r_i_cnt != '0) ? ST_LOAD_I : ST_RUN;
        end
      end
      ST_LOAD_I: begin
        if (w_accept) w_idx_nxt = r_idx + IW'(1);
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, index and run-flag registers. cpu_run tracks the next state, so it
  // rises together with RUN and the first fetch sees a complete program image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cpu_run <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cpu_run <= (w_state_nxt == ST_RUN);
    end
  end

  // Latch both image sizes when a sequence is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_cnt <= '0;
      r_i_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_d_cnt <= d_count;
      r_i_cnt <= i_count;
    end
  end

  // Registered write port: one enable pulse per accepted word, one cycle later.
  // Reset clears the pending pulse so an aborted load leaves nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_enb_d <= 1'b0;
      r_wr_enb_i <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_dat   <= '0;
    end else begin
      r_wr_enb_d <= w_accept && (r_state == ST_LOAD_D);
      r_wr_enb_i <= w_accept && (r_state == ST_LOAD_I);
      if (w_accept) begin
        r_wr_addr <= {r_idx, 2'b00};
        r_wr_dat  <= s_data;
      end
    end
  end

  // Data BRAM arbitration. In RUN the CPU store passes straight through. The
  // loader's final data write lands in the first cycle after LOAD_D, which can
  // already be RUN, so a pending loader pulse still takes priority.
  always_comb begin
    w_cpu_owns_dmem = (r_state == ST_RUN) && !r_wr_enb_d;
    if (w_cpu_owns_dmem) begin
      dmem_w_addr = cpu_d_w_addr;
      dmem_w_dat  = cpu_d_w_dat;
      dmem_w_enb  = cpu_d_w_enb;
    end else begin
      dmem_w_addr = r_wr_addr;
      dmem_w_dat  = r_wr_dat;
      dmem_w_enb  = r_wr_enb_d;
    end
  end

  assign s_ready     = w_loading;
  assign busy        = w_loading;
  assign cpu_run     = r_cpu_run;
  assign imem_w_addr = r_wr_addr;
  assign imem_w_dat  = r_wr_dat;
  assign imem_w_enb  = r_wr_enb_i;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: a per-cycle vector table for the full
// load, then hand-written sequences for the multi-cycle corner cases.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  d_count = '0;
  logic [7:0]  i_count = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [9:0]  imem_w_addr;
  logic [31:0] imem_w_dat;
  logic        imem_w_enb;
  logic [9:0]  cpu_d_w_addr = '0;
  logic [31:0] cpu_d_w_dat = '0;
  logic        cpu_d_w_enb = 1'b0;
  logic [9:0]  dmem_w_addr;
  logic [31:0] dmem_w_dat;
  logic        dmem_w_enb;
  logic        cpu_run;
  logic        busy;

  boot_loader_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .d_count(d_count), .i_count(i_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_w_addr(imem_w_addr), .imem_w_dat(imem_w_dat), .imem_w_enb(imem_w_enb),
    .cpu_d_w_addr(cpu_d_w_addr), .cpu_d_w_dat(cpu_d_w_dat), .cpu_d_w_enb(cpu_d_w_enb),
    .dmem_w_addr(dmem_w_addr), .dmem_w_dat(dmem_w_dat), .dmem_w_enb(dmem_w_enb),
    .cpu_run(cpu_run), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h expected=0x%h", nm, act, exp);
    end
  endtask

  // Write-pulse recorder: {addr, data} of every enabled write, sampled mid-cycle.
  logic [41:0] dq[$];
  logic [41:0] iq[$];
  always @(negedge clk) begin
    if (dmem_w_enb) dq.push_back({dmem_w_addr, dmem_w_dat});
    if (imem_w_enb) iq.push_back({imem_w_addr, imem_w_dat});
  end

  typedef struct {
    logic [1:0]  sh;   // {start, halt}
    logic        sv;
    logic [31:0] sd;
    logic        ce;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic [2:0]  st;   // expected {s_ready, busy, cpu_run}
    logic        de;
    logic [9:0]  da;
    logic [31:0] dd;
    logic        ie;
    logic [9:0]  ia;
    logic [31:0] id;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] sh, input logic sv, input logic [31:0] sd,
                              input logic ce, input logic [9:0] ca, input logic [31:0] cd,
                              input logic [2:0] st, input logic de, input logic [9:0] da,
                              input logic [31:0] dd, input logic ie, input logic [9:0] ia,
                              input logic [31:0] id);
    vec_t v;
    v.sh = sh; v.sv = sv; v.sd = sd; v.ce = ce; v.ca = ca; v.cd = cd; v.st = st;
    v.de = de; v.da = da; v.dd = dd; v.ie = ie; v.ia = ia; v.id = id;
    return v;
  endfunction

  localparam logic [31:0] I0 = 32'h00500093;
  localparam logic [31:0] I1 = 32'h00600113;
  localparam logic [31:0] I2 = 32'h402081B3;
  localparam logic [31:0] I3 = 32'h00302023;
  localparam logic [31:0] I4 = 32'h0000006F;

  task automatic run_load(input int d, input int i, input bit thr, input logic [31:0] base,
                          input bit cpu_st, input string nm);
    int ptr = 0;
    int n = d + i;
    int cyc = 0;
    bit tog = 1'b0;
    bit acc;
    int exp_dsz;
    @(negedge clk);
    dq.delete(); iq.delete();
    start = 1'b1; d_count = d[7:0]; i_count = i[7:0];
    if (cpu_st) begin
      cpu_d_w_enb = 1'b1; cpu_d_w_addr = 10'h3C0; cpu_d_w_dat = 32'hBAD0BAD0;
    end
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    while (ptr < n && cyc < 200) begin
      tog = ~tog;
      s_valid = thr ? tog : 1'b1;
      s_data = base + 32'(ptr);
      #1 acc = s_valid && s_ready;
      @(posedge clk); @(negedge clk);
      cyc++;
      if (acc) ptr++;
    end
    s_valid = 1'b0;
    chk({nm, " words accepted"}, 32'(ptr), 32'(n));
    repeat (2) @(negedge clk);
    #1 cpu_d_w_enb = 1'b0;
    // With a CPU store held high, the two RUN cycles after the final loader
    // pulse forward the store.
    exp_dsz = cpu_st ? d + 2 : d;
    chk({nm, " dmem pulse count"}, 32'(dq.size()), 32'(exp_dsz));
    chk({nm, " imem pulse count"}, 32'(iq.size()), 32'(i));
    for (int k = 0; k < d && k < dq.size(); k++)
      chk($sformatf("%s dmem pulse %0d", nm, k), dq[k], {10'(4 * k), base + 32'(k)});
    if (cpu_st && dq.size() > d)
      chk({nm, " cpu store after final load"}, dq[d], {10'h3C0, 32'hBAD0BAD0});
    for (int k = 0; k < i && k < iq.size(); k++)
      chk($sformatf("%s imem pulse %0d", nm, k), iq[k], {10'(4 * k), base + 32'(d + k)});
    chk({nm, " cpu_run"}, 32'(cpu_run), 32'd1);
    chk({nm, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_halt(input string nm);
    @(negedge clk);
    halt = 1'b1;
    #2 chk({nm, " cpu_run before halt edge"}, 32'(cpu_run), 32'd1);
    @(posedge clk); @(negedge clk);
    halt = 1'b0;
    #2 chk({nm, " cpu_run after halt"}, 32'(cpu_run), 32'd0);
    chk({nm, " s_ready after halt"}, 32'(s_ready), 32'd0);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = mk(2'b10, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0,        3'b000, 1'b0, 10'h0, 32'h0,        1'b0, 10'h0,  32'h0);
    vt[1]  = mk(2'b00, 1'b1, 32'h5, 1'b1, 10'hC, 32'hFFFFFFFF, 3'b110, 1'b0, 10'h0, 32'h0,        1'b0, 10'h0,  32'h0);
    vt[2]  = mk(2'b00, 1'b1, 32'h6, 1'b1, 10'hC, 32'hFFFFFFFF, 3'b110, 1'b1, 10'h0, 32'h5,        1'b0, 10'h0,  32'h0);
    vt[3]  = mk(2'b00, 1'b1, I0,    1'b0, 10'h0, 32'h0,        3'b110, 1'b1, 10'h4, 32'h6,        1'b0, 10'h0,  32'h0);
    vt[4]  = mk(2'b00, 1'b1, I1,    1'b0, 10'h0, 32'h0,        3'b110, 1'b0, 10'h0, 32'h0,        1'b1, 10'h0,  I0);
    vt[5]  = mk(2'b00, 1'b1, I2,    1'b0, 10'h0, 32'h0,        3'b110, 1'b0, 10'h0, 32'h0,        1'b1, 10'h4,  I1);
    vt[6]  = mk(2'b00, 1'b1, I3,    1'b0, 10'h0, 32'h0,        3'b110, 1'b0, 10'h0, 32'h0,        1'b1, 10'h8,  I2);
    vt[7]  = mk(2'b00, 1'b1, I4,    1'b0, 10'h0, 32'h0,        3'b110, 1'b0, 10'h0, 32'h0,        1'b1, 10'hC,  I3);
    vt[8]  = mk(2'b00, 1'b0, 32'h0, 1'b1, 10'hC, 32'hFFFFFFFF, 3'b001, 1'b1, 10'hC, 32'hFFFFFFFF, 1'b1, 10'h10, I4);
    vt[9]  = mk(2'b01, 1'b0, 32'h0, 1'b1, 10'h8, 32'h00001234, 3'b001, 1'b1, 10'h8, 32'h00001234, 1'b0, 10'h0,  32'h0);
    vt[10] = mk(2'b00, 1'b0, 32'h0, 1'b1, 10'hC, 32'hFFFFFFFF, 3'b000, 1'b0, 10'h0, 32'h0,        1'b0, 10'h0,  32'h0);

    // Reset values.
    #3;
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cpu_run", 32'(cpu_run), 32'd0);
    chk("reset dmem_w_enb", 32'(dmem_w_enb), 32'd0);
    chk("reset imem_w_enb", 32'(imem_w_enb), 32'd0);
    chk("reset imem_w_addr", 32'(imem_w_addr), 32'd0);
    chk("reset imem_w_dat", imem_w_dat, 32'd0);
    chk("reset dmem_w_dat", dmem_w_dat, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full load, arbitration and halt, cycle by cycle.
    d_count = 8'd2; i_count = 8'd5;
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      start = vt[v].sh[1]; halt = vt[v].sh[0];
      s_valid = vt[v].sv; s_data = vt[v].sd;
      cpu_d_w_enb = vt[v].ce; cpu_d_w_addr = vt[v].ca; cpu_d_w_dat = vt[v].cd;
      #2;
      chk($sformatf("v%0d s_ready", v), 32'(s_ready), 32'(vt[v].st[2]));
      chk($sformatf("v%0d busy", v), 32'(busy), 32'(vt[v].st[1]));
      chk($sformatf("v%0d cpu_run", v), 32'(cpu_run), 32'(vt[v].st[0]));
      chk($sformatf("v%0d dmem_w_enb", v), 32'(dmem_w_enb), 32'(vt[v].de));
      chk($sformatf("v%0d imem_w_enb", v), 32'(imem_w_enb), 32'(vt[v].ie));
      if (vt[v].de) begin
        chk($sformatf("v%0d dmem_w_addr", v), 32'(dmem_w_addr), 32'(vt[v].da));
        chk($sformatf("v%0d dmem_w_dat", v), dmem_w_dat, vt[v].dd);
      end
      if (vt[v].ie) begin
        chk($sformatf("v%0d imem_w_addr", v), 32'(imem_w_addr), 32'(vt[v].ia));
        chk($sformatf("v%0d imem_w_dat", v), imem_w_dat, vt[v].id);
      end
    end
    @(negedge clk);
    start = 1'b0; halt = 1'b0; cpu_d_w_enb = 1'b0; s_valid = 1'b0;

    // Source throttled to every other cycle.
    run_load(3, 2, 1'b1, 32'h000000D0, 1'b0, "throttle");

    // start outside IDLE is ignored.
    @(negedge clk);
    start = 1'b1; d_count = 8'd3; i_count = 8'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    #2;
    chk("start in RUN busy", 32'(busy), 32'd0);
    chk("start in RUN cpu_run", 32'(cpu_run), 32'd1);
    do_halt("halt1");

    // LOAD_D skipped.
    run_load(0, 3, 1'b0, 32'h000000E0, 1'b0, "d0i3");
    do_halt("halt2");

    // Both counts zero: RUN one cycle after start.
    @(negedge clk);
    start = 1'b1; d_count = 8'd0; i_count = 8'd0;
    #2 chk("zero counts cpu_run at start", 32'(cpu_run), 32'd0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    #2 chk("zero counts cpu_run next cycle", 32'(cpu_run), 32'd1);
    chk("zero counts busy", 32'(busy), 32'd0);
    do_halt("halt3");

    // Final data write lands in RUN and still beats a CPU store.
    run_load(2, 0, 1'b0, 32'h000000F0, 1'b1, "d2i0 arb");
    do_halt("halt4");

    // Reset in the middle of the program image.
    @(negedge clk);
    start = 1'b1; d_count = 8'd0; i_count = 8'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 32'h11111111;
    @(posedge clk); @(negedge clk);
    s_data = 32'h22222222;
    @(posedge clk); @(negedge clk);
    #1 chk("midload pending imem pulse", 32'(imem_w_enb), 32'd1);
    dq.delete(); iq.delete();
    rst = 1'b1;
    #1;
    chk("midload rst imem_w_enb", 32'(imem_w_enb), 32'd0);
    chk("midload rst s_ready", 32'(s_ready), 32'd0);
    chk("midload rst busy", 32'(busy), 32'd0);
    chk("midload rst cpu_run", 32'(cpu_run), 32'd0);
    chk("midload rst imem_w_addr", 32'(imem_w_addr), 32'd0);
    chk("midload rst dmem_w_dat", dmem_w_dat, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("after rst no pulses", 32'(dq.size() + iq.size()), 32'd0);
    chk("after rst waits for start", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    // Fresh start reloads from address 0.
    run_load(0, 5, 1'b0, 32'h00000060, 1'b0, "reload");
    do_halt("halt5");
    run_load(1, 1, 1'b0, 32'h00000070, 1'b0, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Boot-time sequencer for the single-core RV32I datapath. It streams a data image and then a program image from a valid/ready word source into the data BRAM and the instruction BRAM. It owns the data BRAM write port while loading and hands that port to the CPU datapath only once the CPU is released. It releases the core (PC un-stall, register-file read enable, instruction read enable) only after both images are written.

## Interface
Parameters:
- ADDR_WIDTH, default 10, BRAM byte-address width.
- DATA_WIDTH, default 32, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load sequence; sampled only in IDLE.
- halt  in  1  return from RUN to IDLE; ignored in other states.
- d_count  in  ADDR_WIDTH-2  number of data words to load, latched on start.
- i_count  in  ADDR_WIDTH-2  number of instruction words to load, latched on start.
- s_valid  in  1  source word valid.
- s_data  in  DATA_WIDTH  source word.
- s_ready  out  1  block accepts a word this cycle.
- imem_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address.
- imem_w_dat  out  DATA_WIDTH  instruction BRAM write data.
- imem_w_enb  out  1  instruction BRAM write enable.
- cpu_d_w_addr  in  ADDR_WIDTH  CPU data-store address (the ALU result).
- cpu_d_w_dat  in  DATA_WIDTH  CPU store data (rs2).
- cpu_d_w_enb  in  1  CPU store enable (mem_write).
- dmem_w_addr  out  ADDR_WIDTH  data BRAM write address (arbitrated).
- dmem_w_dat  out  DATA_WIDTH  data BRAM write data (arbitrated).
- dmem_w_enb  out  1  data BRAM write enable (arbitrated).
- cpu_run  out  1  core released; drives ~pc_stall, rd_enbl and i_r_enb.
- busy  out  1  high in LOAD_D or LOAD_I.

## Operation
States are IDLE, LOAD_D, LOAD_I and RUN. Reset forces IDLE.

Transitions:
- IDLE: start=1 latches both counts and clears the word index. The next state is LOAD_D if d_count≠0, else LOAD_I if i_count≠0, else RUN.
- LOAD_D: the state persists until the word with index d_count-1 is accepted. The next state is then LOAD_I if i_count≠0, else RUN. The index clears on exit.
- LOAD_I: the state persists until the word with index i_count-1 is accepted, then goes to RUN.
- RUN: halt=1 goes to IDLE.

Word acceptance:
- s_ready = 1 exactly in LOAD_D and LOAD_I. This is combinational from state and does not depend on s_valid.
- A word is accepted when s_valid & s_ready. Only then does the word index increment.
- If s_valid is low, the block waits indefinitely with no timeout.

Write generation:
- Writes are registered. An accept in cycle N produces a write-enable pulse in cycle N+1 with address = {index,2'b00} (byte address, word aligned) and data = s_data.
- In LOAD_D the pulse goes to the dmem port; in LOAD_I it goes to imem.
- The enable is high for exactly one cycle per accepted word. Back-to-back accepts give back-to-back pulses with incrementing addresses.

Data BRAM arbitration:
- In RUN, dmem_w_* equals cpu_d_w_* combinationally.
- In all other states dmem_w_* is driven by the loader, and CPU stores are dropped (not queued).
- The loader's final LOAD_D write pulse, which occurs in the first cycle of the next state, still wins over the CPU.

Status outputs:
- cpu_run = 1 only in RUN; it is registered from state.
- busy is high in LOAD_D and LOAD_I.

Arithmetic:
- The index is ADDR_WIDTH-2 bits wide, so at most 2^(ADDR_WIDTH-2)-1 words per image (255 at default).
- Addresses never wrap within one image.

## Timing
- Reset values: s_ready=0, imem_w_enb=0, dmem_w_enb=0, all address and data outputs 0, cpu_run=0, busy=0, state IDLE, index 0.
- Reset mid-load aborts immediately and asynchronously. No further write pulses occur, including any pending registered pulse. A fresh start is required.
- start to first possible accept: 1 cycle, because the state becomes LOAD_x at the edge after start.
- Last instruction accept in cycle N:
  - the final imem pulse occurs in N+1;
  - RUN is entered at the edge ending N;
  - cpu_run rises in N+1, so the first fetch sees the last instruction already written.
- halt in RUN at cycle N: cpu_run falls in N+1, and the CPU's store in cycle N is still forwarded.
- start asserted outside IDLE is ignored.
- halt and start together in IDLE: start wins.

## Test plan
- Full load: d_count=2 with words 0x00000005, 0x00000006, then i_count=5 with a sub program. Required: dmem pulses at 0x0 and 0x4, then imem pulses at 0x0 to 0x10; cpu_run rises one cycle after the 5th accept; busy is high only during loading.
- Source throttling: toggle s_valid every other cycle. Required: exactly one write pulse per accept, no duplicate or skipped addresses, and the final state is RUN.
- Zero counts:
  - d_count=0, i_count=3: LOAD_D is skipped and there are no dmem pulses.
  - d_count=0, i_count=0: RUN is reached one cycle after start.
- Arbitration:
  - During LOAD_D, cpu_d_w_enb=1 with address 0xC and data 0xFFFFFFFF: the BRAM receives loader values only.
  - In RUN, the same stimulus appears on dmem_w_* in the same cycle.
- Reset mid-load: assert rst after 2 of 5 instruction accepts. Required: all outputs reach reset values asynchronously, there are no further pulses, and a subsequent start reloads from index 0.
- Halt/restart: halt in RUN drops cpu_run next cycle; start with new counts reloads, and the images are rewritten at addresses starting from 0x0.
